// File: rtl/error_weight_adapter_pkg.sv
// Shared types and helpers for the sign-sign LMS weight adapter.
// DEFAULT_WEIGHT is also used when instantiating the ErrorCombiner so both agree on the start-up weights.
package error_weight_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  localparam int DEFAULT_WEIGHT = 1;

  // Width-independent sign: caller passes the MSB and a nonzero flag.
  function automatic logic signed [1:0] sgn(input logic neg, input logic nonzero);
    if (!nonzero)  return 2'sd0;
    else if (neg)  return -2'sd1;
    else           return 2'sd1;
  endfunction

  function automatic logic signed [1:0] sign_product(input logic signed [1:0] a,
                                                     input logic signed [1:0] b);
    if (a == 2'sd0 || b == 2'sd0) return 2'sd0;
    else if (a == b)              return 2'sd1;
    else                          return -2'sd1;
  endfunction

endpackage

// File: rtl/error_weight_adapter_weight_lane.sv
// One adaptation lane: vote accumulator, per-sample sign product and saturating weight register.
module weight_lane
  import error_weight_adapter_pkg::*;
#(
  parameter int ERROR_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int UPDATE_LOG2  = 4,
  parameter int VOTE_THRESH  = 8,
  parameter int WEIGHT_INIT  = DEFAULT_WEIGHT,
  parameter int WEIGHT_MIN   = 0,
  parameter int WEIGHT_MAX   = 7
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    add_i,
  input  logic                    apply_i,
  input  logic [ERROR_WIDTH-1:0]  error_i,
  input  logic [ERROR_WIDTH-1:0]  error_comb_i,
  output logic [WEIGHT_WIDTH-1:0] weight_o
);

  localparam int VW = UPDATE_LOG2 + 2;
  localparam logic signed [VW-1:0]           THR   = VW'(VOTE_THRESH);
  localparam logic signed [VW-1:0]           NTHR  = -THR;
  localparam logic signed [WEIGHT_WIDTH-1:0] WMIN  = WEIGHT_WIDTH'(WEIGHT_MIN);
  localparam logic signed [WEIGHT_WIDTH-1:0] WMAX  = WEIGHT_WIDTH'(WEIGHT_MAX);
  localparam logic signed [WEIGHT_WIDTH-1:0] WINIT = WEIGHT_WIDTH'(WEIGHT_INIT);
  localparam logic signed [WEIGHT_WIDTH-1:0] ONE   = WEIGHT_WIDTH'(1);

  logic signed [1:0]              v;
  logic signed [VW-1:0]           vote_q, vote_d, vote_final;
  logic signed [WEIGHT_WIDTH-1:0] weight_q, weight_d;

  always_comb begin
    v = sign_product(sgn(error_comb_i[ERROR_WIDTH-1], |error_comb_i),
                     sgn(error_i[ERROR_WIDTH-1], |error_i));
    // The window's final sample is folded in here so the step lands on the accepting edge.
    vote_final = vote_q + VW'(v);
    vote_d = clear_i ? '0 : vote_q;
    if (add_i) vote_d = vote_d + VW'(v);
    weight_d = weight_q;
    if (apply_i) begin
      if (vote_final >= THR)
        weight_d = (weight_q > WMIN) ? weight_q - ONE : WMIN;
      else if (vote_final <= NTHR)
        weight_d = (weight_q < WMAX) ? weight_q + ONE : WMAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vote_q   <= '0;
      weight_q <= WINIT;
    end else begin
      vote_q   <= vote_d;
      weight_q <= weight_d;
    end
  end

  assign weight_o = weight_q;

endmodule

// File: rtl/error_weight_adapter.sv
// Decimated sign-sign LMS adapter producing the four ErrorCombiner weights.
// Holds the window FSM and sample counter; per-channel work lives in weight_lane.
module error_weight_adapter
  import error_weight_adapter_pkg::*;
#(
  parameter int ERROR_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int UPDATE_LOG2  = 4,
  parameter int VOTE_THRESH  = 8,
  parameter int WEIGHT_INIT  = DEFAULT_WEIGHT,
  parameter int WEIGHT_MIN   = 0,
  parameter int WEIGHT_MAX   = 7
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    valid_i,
  input  logic [ERROR_WIDTH-1:0]  error_0_i,
  input  logic [ERROR_WIDTH-1:0]  error_1_i,
  input  logic [ERROR_WIDTH-1:0]  error_2_i,
  input  logic [ERROR_WIDTH-1:0]  error_3_i,
  input  logic [ERROR_WIDTH-1:0]  error_comb_i,
  output logic [WEIGHT_WIDTH-1:0] weight_0_o,
  output logic [WEIGHT_WIDTH-1:0] weight_1_o,
  output logic [WEIGHT_WIDTH-1:0] weight_2_o,
  output logic [WEIGHT_WIDTH-1:0] weight_3_o,
  output logic                    update_o
);

  state_e                 state_q;
  logic [UPDATE_LOG2-1:0] cnt_q;
  logic                   update_q;
  logic                   take, last, clear, add;
  logic [ERROR_WIDTH-1:0]  err [4];
  logic [WEIGHT_WIDTH-1:0] wgt [4];

  assign err[0] = error_0_i;
  assign err[1] = error_1_i;
  assign err[2] = error_2_i;
  assign err[3] = error_3_i;

  // Weights step on the edge accepting the final sample; APPLY is the cycle they are shown,
  // and a sample arriving then opens the next window on top of cleared votes.
  always_comb begin
    take  = valid_i && enable_i && (state_q != ST_IDLE);
    last  = take && (state_q == ST_ACCUM) && (cnt_q == '1);
    clear = !enable_i || (state_q != ST_ACCUM) || last;
    add   = take && !last;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      update_q <= 1'b0;
    end else begin
      update_q <= last;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (enable_i) state_q <= ST_ACCUM;
        end
        ST_ACCUM, ST_APPLY: begin
          if (!enable_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (take) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= last ? ST_APPLY : ST_ACCUM;
          end else begin
            state_q <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    weight_lane #(
      .ERROR_WIDTH (ERROR_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .UPDATE_LOG2 (UPDATE_LOG2),
      .VOTE_THRESH (VOTE_THRESH),
      .WEIGHT_INIT (WEIGHT_INIT),
      .WEIGHT_MIN  (WEIGHT_MIN),
      .WEIGHT_MAX  (WEIGHT_MAX)
    ) u_lane (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear),
      .add_i       (add),
      .apply_i     (last),
      .error_i     (err[k]),
      .error_comb_i(error_comb_i),
      .weight_o    (wgt[k])
    );
  end

  assign weight_0_o = wgt[0];
  assign weight_1_o = wgt[1];
  assign weight_2_o = wgt[2];
  assign weight_3_o = wgt[3];
  assign update_o   = update_q;

endmodule

// File: tb/tb_error_weight_adapter.sv
// Scoreboard bench for error_weight_adapter: stimulus pushes expected weights, a monitor checks them.
module tb_error_weight_adapter;

  logic       clk = 1'b0;
  logic       reset_i, enable_i, valid_i;
  logic [7:0] e0, e1, e2, e3, ec;
  logic [3:0] w0, w1, w2, w3;
  logic       update_o;

  typedef struct {
    logic [15:0] w;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cur_id = 0;
  int          last_acc_id = 0;
  logic [15:0] exp_w = 16'h1111;

  always #5 clk = ~clk;

  error_weight_adapter #(
    .ERROR_WIDTH(8), .WEIGHT_WIDTH(4), .UPDATE_LOG2(4), .VOTE_THRESH(8),
    .WEIGHT_INIT(1), .WEIGHT_MIN(0), .WEIGHT_MAX(7)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .valid_i(valid_i),
    .error_0_i(e0), .error_1_i(e1), .error_2_i(e2), .error_3_i(e3),
    .error_comb_i(ec),
    .weight_0_o(w0), .weight_1_o(w1), .weight_2_o(w2), .weight_3_o(w3),
    .update_o(update_o)
  );

  always @(posedge clk) if (valid_i) last_acc_id = cur_id;

  // Monitor: each update pops one expectation; between updates weights must hold.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (update_o) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL spurious_update: update_o=1 after sample %0d, required no update", last_acc_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({w0, w1, w2, w3} !== e.w || last_acc_id != e.id) begin
            fails++;
            $display("FAIL update: weights=%h after sample %0d, required %h after sample %0d",
                     {w0, w1, w2, w3}, last_acc_id, e.w, e.id);
          end
          exp_w = e.w;
        end
      end else begin
        checks++;
        if ({w0, w1, w2, w3} !== exp_w) begin
          fails++;
          $display("FAIL hold: weights=%h, required %h", {w0, w1, w2, w3}, exp_w);
        end
      end
    end
  end

  task automatic send(input int c, input int a0, input int a1, input int a2, input int a3);
    ec = 8'(c); e0 = 8'(a0); e1 = 8'(a1); e2 = 8'(a2); e3 = 8'(a3);
    valid_i = 1'b1;
    cur_id++;
    @(posedge clk); #1;
    valid_i = 1'b0;
    ec = '0; e0 = '0; e1 = '0; e2 = '0; e3 = '0;
  endtask

  task automatic expect_upd(input int a, input int b, input int c, input int d);
    exp_t e;
    e.w  = {4'(a), 4'(b), 4'(c), 4'(d)};
    e.id = cur_id + 1;
    sb.push_back(e);
  endtask

  task automatic window(input int c, input int a0, input int a1, input int a2, input int a3,
                        input int x0, input int x1, input int x2, input int x3);
    repeat (15) send(c, a0, a1, a2, a3);
    expect_upd(x0, x1, x2, x3);
    send(c, a0, a1, a2, a3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_w   = 16'h1111;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; valid_i = 1'b0;
    ec = '0; e0 = '0; e1 = '0; e2 = '0; e3 = '0;
    do_reset();

    @(negedge clk);
    checks++;
    if (update_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_update: update_o=%b, required 0", update_o);
    end
    #1;

    // Partial window then reset: must not shorten the next window.
    enable_i = 1'b1;
    idle(1);
    repeat (9) send(10, 5, 0, 0, 0);
    do_reset();
    idle(1);
    window(10, 5, 0, 0, 0,  0, 1, 1, 1);
    idle(2);
    window(10, 5, 0, 0, 0,  0, 1, 1, 1);

    // Disagreement on channel 1 climbs to the upper bound and saturates.
    for (int k = 1; k <= 8; k++)
      window(10, 0, -3, 0, 0,  0, (k + 1 > 7) ? 7 : k + 1, 1, 1);

    // Vote of 7 is below threshold, but update still pulses.
    repeat (7) send(10, 0, 0, 5, 0);
    repeat (8) send(10, 0, 0, 0, 0);
    expect_upd(0, 7, 1, 1);
    send(10, 0, 0, 0, 0);

    // Exactly +8 and -8 votes both step.
    repeat (8) send(10, 0, 0, 5, -1);
    repeat (7) send(10, 0, 0, 0, 0);
    expect_upd(0, 7, 0, 2);
    send(10, 0, 0, 0, 0);

    // Negative combined error agreeing with negative channel error.
    window(-4, 0, 0, 0, -2,  0, 7, 0, 1);
    // Zero combined error gives no votes.
    window(0, 5, -5, 5, -5,  0, 7, 0, 1);

    // Enable drop discards a 10-sample partial window that would otherwise step w3.
    idle(1);
    repeat (10) send(10, 0, 0, 0, 5);
    enable_i = 1'b0;
    repeat (3) send(10, 0, 0, 0, 5);
    enable_i = 1'b1;
    idle(1);
    window(10, 0, 0, -3, 0,  0, 7, 1, 1);

    // Back-to-back windows; the sample arriving during APPLY decides the second step.
    window(10, -3, 0, 0, 0,  1, 7, 1, 1);
    repeat (8) send(10, 5, 0, 0, 0);
    repeat (7) send(10, 0, 0, 0, 0);
    expect_upd(0, 7, 1, 1);
    send(10, 0, 0, 0, 0);

    idle(20);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_updates: %0d expected updates never seen, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/error_weight_adapter.md
Name: error_weight_adapter

Overview:
- Produces the four signed channel weights that drive the ErrorCombiner's weight inputs. It closes the loop from the combined error back to the weights.
- Uses a decimated sign-sign LMS rule. Per-channel agreement votes between each channel error and the combined error are accumulated over a window of 2^UPDATE_LOG2 valid samples. At the end of each window, each weight is stepped by ±1 with saturation.
- Sits beside the combiner in the ADPLL loop. It consumes the same per-channel phase errors plus the combiner output, and returns registered weights.

Parameters:
- ERROR_WIDTH, 8, width of the signed channel errors and the combined error.
- WEIGHT_WIDTH, 4, width of the signed weights.
- UPDATE_LOG2, 4, log2 of the number of valid samples per adaptation window (16).
- VOTE_THRESH, 8, minimum |vote| needed to step a weight; range 1..2^UPDATE_LOG2.
- WEIGHT_INIT, 1, reset and initial value of every weight.
- WEIGHT_MIN, 0, lower saturation bound.
- WEIGHT_MAX, 7, upper saturation bound; must be ≤ 2^(WEIGHT_WIDTH-1)-1.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  adaptation enable; low holds the weights and discards the partial window.
- valid_i  in  1  one-cycle strobe marking a valid error sample.
- error_0_i .. error_3_i  in  ERROR_WIDTH each  signed channel errors.
- error_comb_i  in  ERROR_WIDTH  signed combined error from the combiner.
- weight_0_o .. weight_3_o  out  WEIGHT_WIDTH each  signed registered weights.
- update_o  out  1  one-cycle pulse in the cycle the new weights first appear.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: reset_i sampled high on a clk_i edge resets the block. The clock port is clk_i and the reset port is reset_i.
- Reset values: all weights = WEIGHT_INIT, update_o = 0, votes = 0, sample counter = 0, state = IDLE. Reset mid-window discards all accumulation.
- sgn(x) is +1 for x > 0, 0 for x = 0, and −1 for x < 0.
- Per-sample vote for channel k: v_k = sgn(error_comb_i) * sgn(error_k_i), giving a value in {−1, 0, +1}.
- Vote accumulators are signed with UPDATE_LOG2+2 bits and never overflow.
- State IDLE:
  - Weights hold; valid_i is ignored.
  - Moves to ACCUM when enable_i = 1.
- State ACCUM, on each valid_i:
  - Add v_k to vote_k for every channel and increment the counter.
  - On the 2^UPDATE_LOG2-th sample, the counter wraps to 0 and the state moves to APPLY.
- State APPLY (exactly one cycle):
  - If vote_k ≥ VOTE_THRESH, w_k ← max(w_k−1, WEIGHT_MIN).
  - If vote_k ≤ −VOTE_THRESH, w_k ← min(w_k+1, WEIGHT_MAX).
  - Otherwise w_k holds.
  - Votes are cleared and update_o = 1 for this cycle, even if no weight changed.
  - Then move to ACCUM, or to IDLE if enable_i = 0.
- Latency: new weights are visible on the outputs in the cycle after the clock edge that accepted the window's final sample.
- valid_i during APPLY: the sample is the first sample of the next window. Votes load v_k rather than being cleared to 0, and the counter becomes 1.
- enable_i low in ACCUM or APPLY:
  - Next state is IDLE; votes and counter are cleared.
  - Weights keep their current values. An APPLY already in progress still completes its update in that cycle.
- Saturation: a weight never leaves [WEIGHT_MIN, WEIGHT_MAX]. A step beyond a bound leaves the weight at that bound.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ACCUM, APPLY).
  - sign-function helper.
  - A default-weight constant used in common with the ErrorCombiner instantiation.
- One natural sub-module, weight_lane, instantiated 4 times. Each lane holds the vote accumulator, computes the sign-product, and holds the saturating weight register.
- The top level keeps the FSM and the sample counter.

Test Plan:
- Reset: assert reset_i for 2 cycles → all weights = 1, update_o = 0. Assert reset_i again after 9 samples → votes discarded, and the next update occurs only after 16 fresh samples.
- Agreement descent: enable = 1; 16 samples with error_comb = +10, error_0 = +5, others 0 → one cycle after the 16th sample, w0 = 0, w1..w3 = 1, update_o pulses once. A second identical window → w0 stays 0 (saturation).
- Disagreement ascent to the bound: error_comb = +10, error_1 = −3, 7 windows → w1 = 7. An 8th window → w1 stays 7.
- Threshold: 7 agreeing samples plus 9 samples with error_2 = 0 → vote = 7, no change to w2, but update_o still pulses.
- Enable drop: 10 samples, enable low for 3 cycles, enable high, then 16 samples → exactly one update, after the 16th post-enable sample. Weights are unchanged during the gap.
- valid_i in APPLY: send valid_i back-to-back across a window boundary → that sample counts in the next window, whose update lands after 15 further samples.
